// File: rtl/p15_pkg.sv
// Shared constants and state type for the PSG noise-stream checker.
package p15_pkg;

    localparam int unsigned LFSR_BITS_DEF  = 17;
    localparam int unsigned LFSR_TAP0_DEF  = 0;
    localparam int unsigned LFSR_TAP1_DEF  = 3;
    localparam int unsigned ERR_LIMIT_DEF  = 4;
    localparam int unsigned COUNT_BITS_DEF = 8;

    typedef enum logic {
        ACQUIRE,
        TRACK
    } state_e;

endpackage

// File: rtl/p15_lfsr_predict.sv
// Next-bit predictor for the noise LFSR, computed from the received history window.
module p15_lfsr_predict #(
    parameter int unsigned LFSR_BITS = 17,
    parameter int unsigned LFSR_TAP0 = 0,
    parameter int unsigned LFSR_TAP1 = 3
) (
    input  logic [LFSR_BITS-1:0] i_hist,
    output logic                 o_pred
);

    // The all-zero term mirrors the generator's lock-up escape.
    assign o_pred = (i_hist[LFSR_TAP0] ^ i_hist[LFSR_TAP1]) | (i_hist == '0);

endmodule

// File: rtl/p15_noise_checker.sv
// Receive-side noise checker: rebuilds the LFSR window from the stream, predicts each bit,
// reports lock, per-bit mismatch pulses and a saturating error count.
module p15_noise_checker
    import p15_pkg::*;
#(
    parameter int unsigned LFSR_BITS  = LFSR_BITS_DEF,
    parameter int unsigned LFSR_TAP0  = LFSR_TAP0_DEF,
    parameter int unsigned LFSR_TAP1  = LFSR_TAP1_DEF,
    parameter int unsigned ERR_LIMIT  = ERR_LIMIT_DEF,
    parameter int unsigned COUNT_BITS = COUNT_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_noise_in,
    input  logic                  i_strobe,
    input  logic                  i_resync,
    input  logic                  i_clear_errors,
    output logic                  o_locked,
    output logic                  o_mismatch,
    output logic [COUNT_BITS-1:0] o_error_count
);

    localparam int unsigned FILL_W = $clog2(LFSR_BITS + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LFSR_BITS);
    localparam logic [3:0] CONSEC_LIMIT = 4'(ERR_LIMIT);

    state_e                r_state, w_state_d;
    logic [LFSR_BITS-1:0]  r_hist, w_hist_d;
    logic [FILL_W-1:0]     r_fill, w_fill_d, w_fill_inc;
    logic [3:0]            r_consec, w_consec_d, w_consec_inc;
    logic                  r_mismatch, w_mismatch_d;
    logic [COUNT_BITS-1:0] r_err, w_err_d;
    logic                  w_obs;
    logic                  w_pred;

    p15_lfsr_predict #(
        .LFSR_BITS (LFSR_BITS),
        .LFSR_TAP0 (LFSR_TAP0),
        .LFSR_TAP1 (LFSR_TAP1)
    ) u_predict (
        .i_hist (r_hist),
        .o_pred (w_pred)
    );

    assign w_obs        = ~i_noise_in;
    assign w_fill_inc   = r_fill + 1'b1;
    assign w_consec_inc = r_consec + 1'b1;

    always_comb begin
        w_state_d    = r_state;
        w_hist_d     = r_hist;
        w_fill_d     = r_fill;
        w_consec_d   = r_consec;
        w_mismatch_d = 1'b0;
        w_err_d      = r_err;

        // resync wins over a same-cycle strobe; that bit is dropped.
        if (i_resync) begin
            w_state_d  = ACQUIRE;
            w_fill_d   = '0;
            w_consec_d = '0;
        end else if (i_strobe) begin
            w_hist_d = {w_obs, r_hist[LFSR_BITS-1:1]};
            unique case (r_state)
                ACQUIRE: begin
                    w_fill_d = w_fill_inc;
                    if (w_fill_inc == FILL_FULL) begin
                        w_state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (w_obs != w_pred) begin
                        w_mismatch_d = 1'b1;
                        if (r_err != '1) begin
                            w_err_d = r_err + 1'b1;
                        end
                        if (w_consec_inc == CONSEC_LIMIT) begin
                            w_state_d  = ACQUIRE;
                            w_fill_d   = '0;
                            w_consec_d = '0;
                        end else begin
                            w_consec_d = w_consec_inc;
                        end
                    end else begin
                        w_consec_d = '0;
                    end
                end
            endcase
        end

        if (i_clear_errors) begin
            w_err_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ACQUIRE;
            r_hist     <= '0;
            r_fill     <= '0;
            r_consec   <= '0;
            r_mismatch <= 1'b0;
            r_err      <= '0;
        end else begin
            r_state    <= w_state_d;
            r_hist     <= w_hist_d;
            r_fill     <= w_fill_d;
            r_consec   <= w_consec_d;
            r_mismatch <= w_mismatch_d;
            r_err      <= w_err_d;
        end
    end

    assign o_locked      = (r_state == TRACK);
    assign o_mismatch    = r_mismatch;
    assign o_error_count = r_err;

endmodule
